// File: rtl/handshake_monitor_pkg.sv
// Shared types for the ready/valid handshake monitor: the per-channel state
// encoding, the violation codes and the bit layout of a channel's
// per-cycle violation vector.
package handshake_monitor_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } ch_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DROP    = 2'd1,
    ERR_DATA    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // Bit positions inside a channel's 3-bit violation vector
  localparam int unsigned VIOL_DROP    = 0;
  localparam int unsigned VIOL_DATA    = 1;
  localparam int unsigned VIOL_TIMEOUT = 2;

  // Lowest code wins when one channel reports several violations at once
  function automatic err_code_e viol_to_code(input logic [2:0] viol);
    err_code_e code;
    code = ERR_NONE;
    if (viol[VIOL_DROP])         code = ERR_DROP;
    else if (viol[VIOL_DATA])    code = ERR_DATA;
    else if (viol[VIOL_TIMEOUT]) code = ERR_TIMEOUT;
    return code;
  endfunction

endpackage

// File: rtl/handshake_channel_checker.sv
// Protocol checker for one ready/valid channel: tracks stalls, checks that
// valid and payload hold while stalled, enforces the stall timeout and
// counts completed transfers. Reports this cycle's violations to the top.
module handshake_channel_checker
  import handshake_monitor_pkg::*;
#(
  parameter int DATA_W    = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clear_i,
  output logic [CNT_W-1:0]  xfer_count_o,
  output logic              err_drop_o,
  output logic              err_data_o,
  output logic              err_timeout_o,
  output logic [2:0]        viol_o
);

  localparam int STALL_W = $clog2(MAX_STALL + 1);

  ch_state_e            state_q, state_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0]    cap_q, cap_d;
  // Timeout already reported for the stall in progress
  logic                 timed_out_q, timed_out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           flags_q, flags_d;
  logic [2:0]           viol;
  logic                 xfer;

  // Next-state logic: FSM, stall counter, payload capture and violations
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    cap_d       = cap_q;
    timed_out_d = timed_out_q;
    xfer        = 1'b0;
    viol        = '0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (ready_i) begin
            xfer = 1'b1;
          end else begin
            state_d     = STALL;
            cap_d       = data_i;
            stall_cnt_d = STALL_W'(1);
            timed_out_d = 1'b0;
          end
        end
      end
      STALL: begin
        if (!valid_i) begin
          viol[VIOL_DROP] = 1'b1;
          state_d         = IDLE;
          stall_cnt_d     = '0;
        end else begin
          // The payload must match the captured value, including on the
          // completing cycle
          if (data_i != cap_q) viol[VIOL_DATA] = 1'b1;
          if (ready_i) begin
            xfer        = 1'b1;
            state_d     = IDLE;
            stall_cnt_d = '0;
          end else begin
            if (stall_cnt_q == STALL_W'(MAX_STALL)) begin
              if (!timed_out_q) begin
                viol[VIOL_TIMEOUT] = 1'b1;
                timed_out_d        = 1'b1;
              end
            end else begin
              stall_cnt_d = stall_cnt_q + STALL_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // clear is applied before this cycle's events are accumulated
    cnt_d = clear_i ? '0 : cnt_q;
    if (xfer && (cnt_d != {CNT_W{1'b1}})) cnt_d = cnt_d + CNT_W'(1);
    flags_d = (clear_i ? 3'b000 : flags_q) | viol;
  end

  // Control and status registers; the captured payload is not reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      timed_out_q <= timed_out_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
    end
  end

  // Payload capture register
  always_ff @(posedge clk_i) begin
    cap_q <= cap_d;
  end

  assign xfer_count_o  = cnt_q;
  assign err_drop_o    = flags_q[VIOL_DROP];
  assign err_data_o    = flags_q[VIOL_DATA];
  assign err_timeout_o = flags_q[VIOL_TIMEOUT];
  assign viol_o        = rst_i ? 3'b000 : viol;

endmodule

// File: rtl/handshake_monitor.sv
// Passive ready/valid protocol monitor for N_CH channels, intended to be
// attached to a design with a bind statement. One checker per channel; this
// level prioritises simultaneous violations and latches the first one.
module handshake_monitor
  import handshake_monitor_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 15,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH-1:0]         ch_ready,
  input  logic [N_CH*DATA_W-1:0]  ch_data,
  input  logic                    clear,
  output logic [N_CH*CNT_W-1:0]   xfer_count,
  output logic [N_CH-1:0]         err_drop,
  output logic [N_CH-1:0]         err_data,
  output logic [N_CH-1:0]         err_timeout,
  output logic                    err_any,
  output logic [CH_W-1:0]         first_err_ch,
  output logic [1:0]              first_err_code
);

  logic [N_CH-1:0][2:0] viol;
  err_code_e            hit_code;
  logic [CH_W-1:0]      hit_ch;
  err_code_e            first_code_q, first_code_d;
  logic [CH_W-1:0]      first_ch_q, first_ch_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    handshake_channel_checker #(
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .MAX_STALL (MAX_STALL)
    ) u_chk (
      .clk_i         (CLK),
      .rst_i         (RESET),
      .valid_i       (ch_valid[i]),
      .ready_i       (ch_ready[i]),
      .data_i        (ch_data[i*DATA_W +: DATA_W]),
      .clear_i       (clear),
      .xfer_count_o  (xfer_count[i*CNT_W +: CNT_W]),
      .err_drop_o    (err_drop[i]),
      .err_data_o    (err_data[i]),
      .err_timeout_o (err_timeout[i]),
      .viol_o        (viol[i])
    );
  end

  // Priority encode this cycle's violations (lowest channel wins) and load
  // the first-error latch only while it is empty after clear
  always_comb begin
    hit_code = ERR_NONE;
    hit_ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (|viol[i]) begin
        hit_code = viol_to_code(viol[i]);
        hit_ch   = CH_W'(i);
      end
    end
    first_code_d = clear ? ERR_NONE : first_code_q;
    first_ch_d   = clear ? '0 : first_ch_q;
    if ((first_code_d == ERR_NONE) && (hit_code != ERR_NONE)) begin
      first_code_d = hit_code;
      first_ch_d   = hit_ch;
    end
  end

  // First-error latch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      first_code_q <= ERR_NONE;
      first_ch_q   <= '0;
    end else begin
      first_code_q <= first_code_d;
      first_ch_q   <= first_ch_d;
    end
  end

  assign first_err_code = first_code_q;
  assign first_err_ch   = first_ch_q;
  assign err_any        = |{err_drop, err_data, err_timeout};

endmodule
